// File: rtl/freq_sweep_pkg.sv
// rtl/freq_sweep_pkg.sv - shared encodings for the frequency sweep generator
package freq_sweep_pkg;

  // Width of frequency codes, shared with the PLL stage's freq_param
  localparam int CODE_W = 8;

  typedef enum logic [1:0] {
    MODE_SINGLE_UP = 2'd0,
    MODE_SINGLE_DN = 2'd1,
    MODE_TRIANGLE  = 2'd2,
    MODE_SAW       = 2'd3
  } sweep_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - loadable down-counter flagging the last cycle of a dwell
module dwell_timer #(
  parameter int DWELL_W = 20
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               run_q, run_d;

  // A load of N makes expire fire on the Nth cycle after the loading edge (value must be >= 1)
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load) begin
      cnt_d = value - DWELL_W'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - DWELL_W'(1);
      end
    end
  end

  // Counter state register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign expire = run_q && (cnt_q == '0);

endmodule

// File: rtl/freq_sweep_gen.sv
// rtl/freq_sweep_gen.sv - steps freq_param between two codes with programmable step and dwell
module freq_sweep_gen
  import freq_sweep_pkg::*;
#(
  parameter int                        CODE_W     = freq_sweep_pkg::CODE_W,
  parameter int                        DWELL_W    = 20,
  parameter logic [CODE_W-1:0]         RESET_CODE = '0
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [CODE_W-1:0]  start_code,
  input  logic [CODE_W-1:0]  stop_code,
  input  logic [CODE_W-1:0]  step,
  input  logic [DWELL_W-1:0] dwell_cycles,
  output logic [CODE_W-1:0]  freq_param,
  output logic               code_valid,
  output logic               busy,
  output logic               done
);

  sweep_state_e       state_q, state_d;
  sweep_mode_e        mode_q, mode_d;
  logic [CODE_W-1:0]  freq_q, freq_d;
  logic [CODE_W-1:0]  lo_q, lo_d, hi_q, hi_d, step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               dir_up_q, dir_up_d;
  logic               cv_q, cv_d, busy_q, busy_d, done_q, done_d;

  logic               tmr_load, tmr_expire;
  logic [DWELL_W-1:0] tmr_value;
  logic               advance, finish;
  logic [CODE_W-1:0]  next_code;

  // One extra bit so overshoot above hi and borrow below zero are both visible before clamping
  logic [CODE_W:0]    up_sum, dn_diff;
  logic [CODE_W-1:0]  up_code, dn_code;

  assign up_sum  = {1'b0, freq_q} + {1'b0, step_q};
  assign dn_diff = {1'b0, freq_q} - {1'b0, step_q};
  assign up_code = (up_sum > {1'b0, hi_q}) ? hi_q : up_sum[CODE_W-1:0];
  assign dn_code = (dn_diff[CODE_W] || (dn_diff[CODE_W-1:0] < lo_q)) ? lo_q : dn_diff[CODE_W-1:0];

  dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (tmr_expire)
  );

  // Sweep sequencing: config latch on start, per-mode next-code choice on dwell expiry, stop abort
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    freq_d    = freq_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    step_d    = step_q;
    dwell_d   = dwell_q;
    dir_up_d  = dir_up_q;
    cv_d      = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = dwell_q;
    advance   = 1'b0;
    finish    = 1'b0;
    next_code = freq_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          lo_d      = (start_code < stop_code) ? start_code : stop_code;
          hi_d      = (start_code < stop_code) ? stop_code : start_code;
          step_d    = (step == '0) ? CODE_W'(1) : step;
          dwell_d   = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
          mode_d    = sweep_mode_e'(mode);
          freq_d    = (sweep_mode_e'(mode) == MODE_SINGLE_DN) ? hi_d : lo_d;
          dir_up_d  = 1'b1;
          cv_d      = 1'b1;
          busy_d    = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = dwell_d;
          state_d   = ST_DWELL;
        end
      end

      ST_DWELL: begin
        if (stop) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (tmr_expire) begin
          case (mode_q)
            MODE_SINGLE_UP: begin
              if (freq_q == hi_q) finish = 1'b1;
              else begin
                advance   = 1'b1;
                next_code = up_code;
              end
            end
            MODE_SINGLE_DN: begin
              if (freq_q == lo_q) finish = 1'b1;
              else begin
                advance   = 1'b1;
                next_code = dn_code;
              end
            end
            MODE_TRIANGLE: begin
              // With lo == hi there is nothing to step to, so the code is simply held
              if (lo_q != hi_q) begin
                advance = 1'b1;
                if (dir_up_q) begin
                  if (freq_q == hi_q) begin
                    dir_up_d  = 1'b0;
                    next_code = dn_code;
                  end else begin
                    next_code = up_code;
                  end
                end else begin
                  if (freq_q == lo_q) begin
                    dir_up_d  = 1'b1;
                    next_code = up_code;
                  end else begin
                    next_code = dn_code;
                  end
                end
              end
            end
            default: begin
              if (lo_q != hi_q) begin
                advance   = 1'b1;
                next_code = (freq_q == hi_q) ? lo_q : up_code;
              end
            end
          endcase

          if (finish) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (advance) begin
            freq_d   = next_code;
            cv_d     = 1'b1;
            tmr_load = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched configuration and registered outputs
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_SINGLE_UP;
      freq_q   <= RESET_CODE;
      lo_q     <= '0;
      hi_q     <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      dir_up_q <= 1'b1;
      cv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      freq_q   <= freq_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      dir_up_q <= dir_up_d;
      cv_q     <= cv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign freq_param = freq_q;
  assign code_valid = cv_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_freq_sweep_gen.sv
// tb/tb_freq_sweep_gen.sv - directed self-checking bench for freq_sweep_gen
module tb_freq_sweep_gen;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        start, stop;
  logic [1:0]  mode;
  logic [7:0]  start_code, stop_code, step;
  logic [19:0] dwell_cycles;
  logic [7:0]  freq_param;
  logic        code_valid, busy, done;

  int total  = 0;
  int passed = 0;

  logic [10:0] obs, exp_v;

  freq_sweep_gen dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .mode         (mode),
    .start_code   (start_code),
    .stop_code    (stop_code),
    .step         (step),
    .dwell_cycles (dwell_cycles),
    .freq_param   (freq_param),
    .code_valid   (code_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk_in = ~clk_in;

  // Sets the config, pulses start for one cycle; returns at the sample point of cycle 1
  task automatic launch(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] s, input logic [19:0] d);
    mode = m; start_code = a; stop_code = b; step = s; dwell_cycles = d;
    @(negedge clk_in) start = 1'b1;
    @(negedge clk_in) start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;
    start_code = 8'd0; stop_code = 8'd0; step = 8'd0; dwell_cycles = 20'd0;
    #2;
    obs = {freq_param, code_valid, busy, done}; exp_v = {8'd0, 3'b000}; total++;
    if (obs !== exp_v) $display("FAIL reset: got fp=%0d cv/busy/done=%b expected fp=%0d cv/busy/done=%b", obs[10:3], obs[2:0], exp_v[10:3], exp_v[2:0]);
    else passed++;
    @(negedge clk_in) rst_n = 1'b1;
    // stop in IDLE has no effect
    stop = 1'b1;
    @(negedge clk_in) stop = 1'b0;
    @(negedge clk_in);
    obs = {freq_param, code_valid, busy, done}; total++;
    if (obs !== exp_v) $display("FAIL idle_stop: got fp=%0d cv/busy/done=%b expected fp=%0d cv/busy/done=%b", obs[10:3], obs[2:0], exp_v[10:3], exp_v[2:0]);
    else passed++;
  endtask

  task automatic test_single_up();
    int e_fp;
    launch(2'd0, 8'd10, 8'd14, 8'd2, 20'd3);
    // these changes must not disturb the sweep already started
    mode = 2'd3; start_code = 8'd0; stop_code = 8'd200; step = 8'd1; dwell_cycles = 20'd7;
    for (int c = 1; c <= 12; c++) begin
      e_fp = (c <= 3) ? 10 : (c <= 6) ? 12 : 14;
      exp_v = {8'(e_fp), (c == 1 || c == 4 || c == 7), (c <= 9), (c == 10)};
      obs = {freq_param, code_valid, busy, done}; total++;
      if (obs !== exp_v) $display("FAIL single_up c%0d: got fp=%0d cv/busy/done=%b expected fp=%0d cv/busy/done=%b", c, obs[10:3], obs[2:0], exp_v[10:3], exp_v[2:0]);
      else passed++;
      @(negedge clk_in);
    end
  endtask

  task automatic test_single_down();
    int seq [6] = '{20, 13, 6, 5, 5, 5};
    launch(2'd1, 8'd20, 8'd5, 8'd7, 20'd1);
    for (int c = 1; c <= 6; c++) begin
      exp_v = {8'(seq[c-1]), (c <= 4), (c <= 4), (c == 5)};
      obs = {freq_param, code_valid, busy, done}; total++;
      if (obs !== exp_v) $display("FAIL single_down c%0d: got fp=%0d cv/busy/done=%b expected fp=%0d cv/busy/done=%b", c, obs[10:3], obs[2:0], exp_v[10:3], exp_v[2:0]);
      else passed++;
      @(negedge clk_in);
    end
  endtask

  task automatic test_triangle();
    int seq [4] = '{250, 254, 255, 251};
    launch(2'd2, 8'd255, 8'd250, 8'd4, 20'd2);
    for (int c = 1; c <= 16; c++) begin
      exp_v = {8'(seq[((c-1)/2)%4]), (c % 2 == 1), 1'b1, 1'b0};
      obs = {freq_param, code_valid, busy, done}; total++;
      if (obs !== exp_v) $display("FAIL triangle c%0d: got fp=%0d cv/busy/done=%b expected fp=%0d cv/busy/done=%b", c, obs[10:3], obs[2:0], exp_v[10:3], exp_v[2:0]);
      else passed++;
      @(negedge clk_in);
    end
    stop = 1'b1;
    @(negedge clk_in) stop = 1'b0;
    exp_v = {8'd250, 3'b000};
    obs = {freq_param, code_valid, busy, done}; total++;
    if (obs !== exp_v) $display("FAIL triangle_stop: got fp=%0d cv/busy/done=%b expected fp=%0d cv/busy/done=%b", obs[10:3], obs[2:0], exp_v[10:3], exp_v[2:0]);
    else passed++;
  endtask

  task automatic test_sawtooth();
    launch(2'd3, 8'd3, 8'd5, 8'd0, 20'd0);
    for (int c = 1; c <= 9; c++) begin
      exp_v = {8'(3 + (c-1) % 3), 3'b110};
      obs = {freq_param, code_valid, busy, done}; total++;
      if (obs !== exp_v) $display("FAIL sawtooth c%0d: got fp=%0d cv/busy/done=%b expected fp=%0d cv/busy/done=%b", c, obs[10:3], obs[2:0], exp_v[10:3], exp_v[2:0]);
      else passed++;
      @(negedge clk_in);
    end
    stop = 1'b1;
    @(negedge clk_in) stop = 1'b0;
    exp_v = {8'd3, 3'b000};
    obs = {freq_param, code_valid, busy, done}; total++;
    if (obs !== exp_v) $display("FAIL sawtooth_stop: got fp=%0d cv/busy/done=%b expected fp=%0d cv/busy/done=%b", obs[10:3], obs[2:0], exp_v[10:3], exp_v[2:0]);
    else passed++;
  endtask

  task automatic test_equal_endpoints();
    // continuous mode with lo == hi: one code_valid, then hold while busy
    launch(2'd2, 8'd7, 8'd7, 8'd3, 20'd1);
    for (int c = 1; c <= 5; c++) begin
      exp_v = {8'd7, (c == 1), 1'b1, 1'b0};
      obs = {freq_param, code_valid, busy, done}; total++;
      if (obs !== exp_v) $display("FAIL equal_cont c%0d: got fp=%0d cv/busy/done=%b expected fp=%0d cv/busy/done=%b", c, obs[10:3], obs[2:0], exp_v[10:3], exp_v[2:0]);
      else passed++;
      @(negedge clk_in);
    end
    stop = 1'b1;
    @(negedge clk_in) stop = 1'b0;
    // single mode with lo == hi: hold D cycles, then done
    launch(2'd0, 8'd9, 8'd9, 8'd1, 20'd2);
    for (int c = 1; c <= 4; c++) begin
      exp_v = {8'd9, (c == 1), (c <= 2), (c == 3)};
      obs = {freq_param, code_valid, busy, done}; total++;
      if (obs !== exp_v) $display("FAIL equal_single c%0d: got fp=%0d cv/busy/done=%b expected fp=%0d cv/busy/done=%b", c, obs[10:3], obs[2:0], exp_v[10:3], exp_v[2:0]);
      else passed++;
      @(negedge clk_in);
    end
  endtask

  task automatic test_stop_and_busy_start();
    int e_fp;
    launch(2'd0, 8'd10, 8'd14, 8'd2, 20'd3);
    for (int c = 1; c <= 8; c++) begin
      e_fp = (c <= 3) ? 10 : 12;
      if (c <= 5) exp_v = {8'(e_fp), (c == 1 || c == 4), 1'b1, 1'b0};
      else        exp_v = {8'd12, 3'b000};
      obs = {freq_param, code_valid, busy, done}; total++;
      if (obs !== exp_v) $display("FAIL stop_mid c%0d: got fp=%0d cv/busy/done=%b expected fp=%0d cv/busy/done=%b", c, obs[10:3], obs[2:0], exp_v[10:3], exp_v[2:0]);
      else passed++;
      if (c == 2) begin start = 1'b1; start_code = 8'd0; end
      if (c == 3) start = 1'b0;
      if (c == 5) stop = 1'b1;
      if (c == 6) stop = 1'b0;
      @(negedge clk_in);
    end
    // start and stop together in IDLE: no sweep
    start_code = 8'd10; start = 1'b1; stop = 1'b1;
    @(negedge clk_in) begin start = 1'b0; stop = 1'b0; end
    for (int c = 1; c <= 3; c++) begin
      exp_v = {8'd12, 3'b000};
      obs = {freq_param, code_valid, busy, done}; total++;
      if (obs !== exp_v) $display("FAIL start_stop_idle c%0d: got fp=%0d cv/busy/done=%b expected fp=%0d cv/busy/done=%b", c, obs[10:3], obs[2:0], exp_v[10:3], exp_v[2:0]);
      else passed++;
      @(negedge clk_in);
    end
  endtask

  task automatic test_async_reset();
    launch(2'd0, 8'd10, 8'd14, 8'd2, 20'd3);
    repeat (4) @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    exp_v = {8'd0, 3'b000};
    obs = {freq_param, code_valid, busy, done}; total++;
    if (obs !== exp_v) $display("FAIL async_reset: got fp=%0d cv/busy/done=%b expected fp=%0d cv/busy/done=%b", obs[10:3], obs[2:0], exp_v[10:3], exp_v[2:0]);
    else passed++;
    @(negedge clk_in) rst_n = 1'b1;
    launch(2'd0, 8'd14, 8'd10, 8'd2, 20'd3);
    for (int c = 1; c <= 2; c++) begin
      exp_v = {8'd10, (c == 1), 1'b1, 1'b0};
      obs = {freq_param, code_valid, busy, done}; total++;
      if (obs !== exp_v) $display("FAIL post_reset c%0d: got fp=%0d cv/busy/done=%b expected fp=%0d cv/busy/done=%b", c, obs[10:3], obs[2:0], exp_v[10:3], exp_v[2:0]);
      else passed++;
      @(negedge clk_in);
    end
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_single_down();
    test_triangle();
    test_sawtooth();
    test_equal_endpoints();
    test_stop_and_busy_start();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
